// File: rtl/axc_div.sv
// Tunable approximate sequential signed divider: restoring division on operand
// magnitudes, C_in quotient bits MSB first. Define AXC_DIV_ROUND_EN for midpoint compensation.
module axc_div #(
    parameter int NN = 8,
    parameter int ND = 8
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  START,
    input  logic [NN-1:0]         N_in,
    input  logic [ND-1:0]         D_in,
    input  logic [$clog2(NN):0]   C_in,
    output logic [NN-1:0]         Q_out,
    output logic [ND-1:0]         R_out,
    output logic                  Done_out,
    output logic                  DivZero_out
);
    localparam int CW = $clog2(NN) + 1;

    // state  | meaning
    // S_IDLE | waiting for START, outputs zero since reset
    // S_CALC | one quotient bit per edge while cnt != 0, then result edge
    // S_DONE | result valid and held; START restarts
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [NN-1:0] nrem_q, nrem_d;
    logic [ND-1:0] dmag_q, dmag_d;
    logic [ND:0]   p_q, p_d;
    logic [NN-1:0] qbits_q, qbits_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] k_q, k_d;
    logic          sgn_q_q, sgn_q_d;
    logic          sgn_r_q, sgn_r_d;
    logic          dz_q, dz_d;
    logic [NN-1:0] q_out_q, q_out_d;
    logic [ND-1:0] r_out_q, r_out_d;
    logic          done_q, done_d;
    logic          divzero_q, divzero_d;

    logic [ND:0]   p_shift, p_step;
    logic          ge;
    logic [CW-1:0] k_sel, shamt;
    logic [NN-1:0] qmag, n_abs;
    logic [ND-1:0] d_abs, p_lo;

    always_comb begin
        n_abs   = N_in[NN-1] ? (~N_in + 1'b1) : N_in;
        d_abs   = D_in[ND-1] ? (~D_in + 1'b1) : D_in;
        k_sel   = ((C_in == '0) || (C_in > CW'(NN))) ? CW'(NN) : C_in;

        p_shift = {p_q[ND-1:0], nrem_q[NN-1]};
        ge      = (p_shift >= {1'b0, dmag_q});
        p_step  = ge ? (p_shift - {1'b0, dmag_q}) : p_shift;

        // qbits holds the k computed bits right-aligned; move them to the top.
        shamt   = CW'(NN) - k_q;
        qmag    = qbits_q << shamt;
`ifdef AXC_DIV_ROUND_EN
        if (k_q < CW'(NN)) begin
            qmag = qmag | ((NN'(1) << shamt) >> 1);
        end
`endif
        p_lo    = p_q[ND-1:0];
    end

    always_comb begin
        state_d   = state_q;
        nrem_d    = nrem_q;
        dmag_d    = dmag_q;
        p_d       = p_q;
        qbits_d   = qbits_q;
        cnt_d     = cnt_q;
        k_d       = k_q;
        sgn_q_d   = sgn_q_q;
        sgn_r_d   = sgn_r_q;
        dz_d      = dz_q;
        q_out_d   = q_out_q;
        r_out_d   = r_out_q;
        done_d    = done_q;
        divzero_d = divzero_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (START) begin
                    state_d   = S_CALC;
                    nrem_d    = n_abs;
                    dmag_d    = d_abs;
                    p_d       = '0;
                    qbits_d   = '0;
                    k_d       = k_sel;
                    sgn_q_d   = N_in[NN-1] ^ D_in[ND-1];
                    sgn_r_d   = N_in[NN-1];
                    dz_d      = (D_in == '0);
                    // Divide-by-zero skips the iterations and only takes the result edge.
                    cnt_d     = (D_in == '0) ? '0 : k_sel;
                    done_d    = 1'b0;
                    divzero_d = 1'b0;
                end
            end
            S_CALC: begin
                if (cnt_q != '0) begin
                    p_d     = p_step;
                    qbits_d = {qbits_q[NN-2:0], ge};
                    nrem_d  = nrem_q << 1;
                    cnt_d   = cnt_q - 1'b1;
                end else begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    if (dz_q) begin
                        q_out_d   = '1;
                        r_out_d   = '0;
                        divzero_d = 1'b1;
                    end else begin
                        q_out_d = sgn_q_q ? (~qmag + 1'b1) : qmag;
                        r_out_d = sgn_r_q ? (~p_lo + 1'b1) : p_lo;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= S_IDLE;
            nrem_q    <= '0;
            dmag_q    <= '0;
            p_q       <= '0;
            qbits_q   <= '0;
            cnt_q     <= '0;
            k_q       <= '0;
            sgn_q_q   <= 1'b0;
            sgn_r_q   <= 1'b0;
            dz_q      <= 1'b0;
            q_out_q   <= '0;
            r_out_q   <= '0;
            done_q    <= 1'b0;
            divzero_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            nrem_q    <= nrem_d;
            dmag_q    <= dmag_d;
            p_q       <= p_d;
            qbits_q   <= qbits_d;
            cnt_q     <= cnt_d;
            k_q       <= k_d;
            sgn_q_q   <= sgn_q_d;
            sgn_r_q   <= sgn_r_d;
            dz_q      <= dz_d;
            q_out_q   <= q_out_d;
            r_out_q   <= r_out_d;
            done_q    <= done_d;
            divzero_q <= divzero_d;
        end
    end

    assign Q_out       = q_out_q;
    assign R_out       = r_out_q;
    assign Done_out    = done_q;
    assign DivZero_out = divzero_q;

endmodule

// File: tb/tb_axc_div.sv
// Directed vector bench for axc_div (NN = ND = 8), with hand sequences for
// START-in-CALC, START-in-DONE and asynchronous reset mid-operation.
module tb_axc_div;
    logic       CLK;
    logic       RST_N;
    logic       START;
    logic [7:0] N_in;
    logic [7:0] D_in;
    logic [3:0] C_in;
    logic [7:0] Q_out;
    logic [7:0] R_out;
    logic       Done_out;
    logic       DivZero_out;

    int n_cmp = 0;
    int n_err = 0;

    axc_div #(.NN(8), .ND(8)) dut (
        .CLK(CLK), .RST_N(RST_N), .START(START),
        .N_in(N_in), .D_in(D_in), .C_in(C_in),
        .Q_out(Q_out), .R_out(R_out),
        .Done_out(Done_out), .DivZero_out(DivZero_out)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

`ifdef AXC_DIV_ROUND_EN
    localparam logic [7:0] Q120_4  = 8'h28;
    localparam logic [7:0] Q100_2  = 8'h20;
    localparam logic [7:0] QN100_2 = 8'hE0;
    localparam logic [7:0] Q100_1  = 8'h40;
`else
    localparam logic [7:0] Q120_4  = 8'h20;
    localparam logic [7:0] Q100_2  = 8'h00;
    localparam logic [7:0] QN100_2 = 8'h00;
    localparam logic [7:0] Q100_1  = 8'h00;
`endif

    typedef struct {
        logic [7:0] n;
        logic [7:0] d;
        logic [3:0] c;
        logic [7:0] q;
        logic [7:0] r;
        logic       dz;
        int         lat;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Waits for Done_out after the START sampling edge; lat_in edges already elapsed.
    task automatic wait_done(input string tag, input int lat_in, input int exp_lat);
        int lat;
        lat = lat_in;
        while (!Done_out && lat < 20) begin
            @(posedge CLK);
            #1;
            lat++;
        end
        check({tag, "_latency"}, lat, exp_lat);
    endtask

    task automatic do_op(input string tag, input logic [7:0] n, input logic [7:0] d,
                         input logic [3:0] c, input logic [7:0] eq, input logic [7:0] er,
                         input logic edz, input int elat);
        N_in  = n;
        D_in  = d;
        C_in  = c;
        START = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
        check({tag, "_done_clr"}, int'(Done_out), 0);
        wait_done(tag, 0, elat);
        check({tag, "_q"}, int'(Q_out), int'(eq));
        check({tag, "_r"}, int'(R_out), int'(er));
        check({tag, "_dz"}, int'(DivZero_out), int'(edz));
    endtask

    initial begin
        vecs[0]  = '{8'd100, 8'd7,   4'd8,  8'h0E,   8'h02, 1'b0, 9};
        vecs[1]  = '{8'h9C,  8'd7,   4'd8,  8'hF2,   8'hFE, 1'b0, 9};
        vecs[2]  = '{8'd100, 8'hF9,  4'd8,  8'hF2,   8'h02, 1'b0, 9};
        vecs[3]  = '{8'h9C,  8'hF9,  4'd8,  8'h0E,   8'hFE, 1'b0, 9};
        vecs[4]  = '{8'd120, 8'd3,   4'd4,  Q120_4,  8'h01, 1'b0, 5};
        vecs[5]  = '{8'd120, 8'd3,   4'd0,  8'h28,   8'h00, 1'b0, 9};
        vecs[6]  = '{8'd120, 8'd3,   4'd15, 8'h28,   8'h00, 1'b0, 9};
        vecs[7]  = '{8'd55,  8'd0,   4'd8,  8'hFF,   8'h00, 1'b1, 1};
        vecs[8]  = '{8'h80,  8'hFF,  4'd8,  8'h80,   8'h00, 1'b0, 9};
        vecs[9]  = '{8'd100, 8'd7,   4'd2,  Q100_2,  8'h01, 1'b0, 3};
        vecs[10] = '{8'h9C,  8'd7,   4'd1,  Q100_1 == 8'h40 ? 8'hC0 : 8'h00, 8'h00, 1'b0, 2};

        RST_N = 1'b0;
        START = 1'b0;
        N_in  = '0;
        D_in  = '0;
        C_in  = '0;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_q", int'(Q_out), 0);
        check("rst_r", int'(R_out), 0);
        check("rst_done", int'(Done_out), 0);
        check("rst_dz", int'(DivZero_out), 0);
        RST_N = 1'b1;
        @(posedge CLK);
        #1;

        for (int i = 0; i < 11; i++) begin
            do_op($sformatf("vec%0d", i), vecs[i].n, vecs[i].d, vecs[i].c,
                  vecs[i].q, vecs[i].r, vecs[i].dz, vecs[i].lat);
        end

        // Negative dividend with partial quotient: remainder negated, rounded quotient negated.
        do_op("neg_k2", 8'h9C, 8'd7, 4'd2, QN100_2, 8'hFF, 1'b0, 3);

        // START re-asserted on the third CALC cycle must not restart.
        N_in  = 8'd100;
        D_in  = 8'd7;
        C_in  = 4'd8;
        START = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        N_in  = 8'd44;
        D_in  = 8'd2;
        START = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
        wait_done("calc_start", 3, 9);
        check("calc_start_q", int'(Q_out), 8'h0E);
        check("calc_start_r", int'(R_out), 8'h02);

        // Restart straight from DONE.
        do_op("done_restart", 8'd44, 8'd2, 4'd8, 8'h16, 8'h00, 1'b0, 9);

        // Asynchronous reset in the middle of CALC, released off the clock edge.
        N_in  = 8'd100;
        D_in  = 8'd7;
        C_in  = 4'd8;
        START = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
        repeat (3) @(posedge CLK);
        #3;
        RST_N = 1'b0;
        #1;
        check("arst_q", int'(Q_out), 0);
        check("arst_r", int'(R_out), 0);
        check("arst_done", int'(Done_out), 0);
        RST_N = 1'b1;
        repeat (10) @(posedge CLK);
        #1;
        check("arst_no_result", int'(Done_out), 0);
        do_op("after_rst", 8'd127, 8'd127, 4'd8, 8'h01, 8'h00, 1'b0, 9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
